// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU unit: 32-step restoring divider with a 3-state FSM and pipeline stall handshake.
// Optional macro DIV_ZERO_FAST_EN: zero divisor completes directly from IDLE to DONE.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        annul,
    output logic        stall_o,
    output logic        ready,
    output logic [63:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] rem_q, rem_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] result_q, result_d;

    logic [31:0] opa_mag;
    logic [31:0] opb_mag;
    logic [32:0] trial;
    logic [63:0] step_rem;
    logic [31:0] quo_fin;
    logic [31:0] rmd_fin;
    logic        accept;

    assign accept  = (state_q == IDLE) && start && !annul;
    assign opa_mag = (signed_div && opa[31]) ? (32'd0 - opa) : opa;
    assign opb_mag = (signed_div && opb[31]) ? (32'd0 - opb) : opb;

    // Upper remainder stays below the divisor, so the shifted-out bit plus
    // the upper word always fits the 33-bit trial subtraction.
    assign trial    = rem_q[63:31] - {1'b0, dvsr_q};
    assign step_rem = trial[32] ? {rem_q[62:0], 1'b0}
                                : {trial[31:0], rem_q[30:0], 1'b1};

    assign quo_fin = qneg_q ? (32'd0 - step_rem[31:0])  : step_rem[31:0];
    assign rmd_fin = rneg_q ? (32'd0 - step_rem[63:32]) : step_rem[63:32];

`ifdef DIV_ZERO_FAST_EN
    logic [63:0] zero_res;
    assign zero_res = {opa, (signed_div && opa[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dvsr_d  = opb_mag;
                    rem_d   = {32'd0, opa_mag};
                    qneg_d  = signed_div && (opa[31] ^ opb[31]);
                    rneg_d  = signed_div && opa[31];
                    cnt_d   = 5'd0;
                    state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (opb == 32'd0) begin
                        state_d  = DONE;
                        result_d = zero_res;
                    end
`endif
                end
            end
            BUSY: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = DONE;
                        result_d = {rmd_fin, quo_fin};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign stall_o = accept || (state_q == BUSY);
    assign ready   = (state_q == DONE);
    assign result  = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl using immediate assertions.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        stall_o;
    logic        ready;
    logic [63:0] result;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .annul      (annul),
        .stall_o    (stall_o),
        .ready      (ready),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a divide in a fresh cycle (cycle 0) and holds start until ready.
    task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          output int rc, output int scnt, output logic s_at_rdy);
        @(posedge clk); #1;
        start = 1'b1; signed_div = sd; opa = a; opb = b; annul = 1'b0;
        #1;
        rc = -1; scnt = 0; s_at_rdy = 1'bx;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #2;
            end
            if (ready === 1'b1) begin
                rc = c;
                s_at_rdy = stall_o;
                break;
            end
            if (stall_o === 1'b1) scnt++;
        end
    endtask

    // Drops start after a completed divide and confirms ready was a single pulse.
    task automatic release_op(input string tag);
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        #1;
        chk(tag, {63'd0, ready}, 64'd0);
    endtask

    int   rc;
    int   scnt;
    logic sar;
    int   rdy_seen;

    initial begin
        rst = 1'b1; start = 1'b0; signed_div = 1'b0;
        opa = '0; opb = '0; annul = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready",  {63'd0, ready},   64'd0);
        chk("rst_stall",  {63'd0, stall_o}, 64'd0);
        chk("rst_result", result,           64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // DIVU 100/7
        do_div(1'b0, 32'd100, 32'd7, rc, scnt, sar);
        chk("divu100_7_lat",    64'(rc),   64'd33);
        chk("divu100_7_stall",  64'(scnt), 64'd33);
        chk("divu100_7_stall33", {63'd0, sar}, 64'd0);
        chk("divu100_7_res",    result, {32'h0000_0002, 32'h0000_000E});
        release_op("divu100_7_pulse");

        // DIV -7/2
        do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, rc, scnt, sar);
        chk("div_m7_2_lat", 64'(rc), 64'd33);
        chk("div_m7_2_res", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        release_op("div_m7_2_pulse");

        // DIV most-negative / -1
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rc, scnt, sar);
        chk("div_ovf_lat", 64'(rc), 64'd33);
        chk("div_ovf_res", result, {32'h0000_0000, 32'h8000_0000});
        release_op("div_ovf_pulse");

        // DIVU 20/3 annulled in cycle 10
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opa = 32'd20; opb = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        #1;
        chk("annul_busy_stall", {63'd0, stall_o}, 64'd1);
        annul = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        #1;
        chk("annul_idle_stall", {63'd0, stall_o}, 64'd0);
        chk("annul_ready",      {63'd0, ready},   64'd0);
        chk("annul_result",     result, {32'h0000_0000, 32'h8000_0000});
        rdy_seen = 0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #2;
            if (ready === 1'b1) rdy_seen++;
        end
        chk("annul_no_ready", 64'(rdy_seen), 64'd0);
        do_div(1'b0, 32'd20, 32'd3, rc, scnt, sar);
        chk("restart_lat", 64'(rc), 64'd33);
        chk("restart_res", result, {32'h0000_0002, 32'h0000_0006});
        release_op("restart_pulse");

        // Zero divisors
        do_div(1'b0, 32'd5, 32'd0, rc, scnt, sar);
        chk("divu5_0_lat",   64'(rc),   64'(ZERO_LAT));
        chk("divu5_0_stall", 64'(scnt), 64'(ZERO_LAT));
        chk("divu5_0_res",   result, {32'h0000_0005, 32'hFFFF_FFFF});
        release_op("divu5_0_pulse");
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, rc, scnt, sar);
        chk("div_m5_0_lat", 64'(rc), 64'(ZERO_LAT));
        chk("div_m5_0_res", result, {32'hFFFF_FFFB, 32'h0000_0001});
        release_op("div_m5_0_pulse");

        // Reset in the middle of BUSY
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
        repeat (15) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #2;
        chk("midrst_ready",  {63'd0, ready},   64'd0);
        chk("midrst_stall",  {63'd0, stall_o}, 64'd0);
        chk("midrst_result", result,           64'd0);
        rst = 1'b0;

        // Back-to-back: second start held straight through the first ready
        do_div(1'b0, 32'd9, 32'd3, rc, scnt, sar);
        chk("b2b_first_lat", 64'(rc), 64'd33);
        chk("b2b_first_res", result, {32'h0000_0000, 32'h0000_0003});
        do_div(1'b0, 32'd10, 32'd4, rc, scnt, sar);
        chk("b2b_second_lat", 64'(rc), 64'd33);
        chk("b2b_second_res", result, {32'h0000_0002, 32'h0000_0002});
        release_op("b2b_pulse");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 The port list SHALL be as follows, clock and reset first:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  DIV/DIVU present in execute stage; held high by the stalled pipeline until ready.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- opa  in  32  dividend (rs); sampled only in the start cycle.
- opb  in  32  divisor (rt); sampled only in the start cycle.
- annul  in  1  flush/exception; cancels any operation.
- stall_o  out  1  pipeline stall request.
- ready  out  1  one-cycle pulse; result valid, HI/LO write enable.
- result  out  64  {hi = remainder, lo = quotient}.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-004 IDLE with start=1 and annul=0: latch |opa|, |opb| (magnitudes when signed_div=1, raw otherwise), quotient sign = opa[31]^opb[31], remainder sign = opa[31]; clear 5-bit counter; go to BUSY.
REQ-005 BUSY SHALL perform one restoring radix-2 step per cycle on a 64-bit partial remainder: shift left 1, subtract divisor from upper 33 bits, keep the difference and set the quotient bit if non-negative.
REQ-006 BUSY SHALL last exactly 32 cycles (counter 0..31); at counter 31, go to DONE.
REQ-007 On BUSY->DONE, result SHALL load the quotient and remainder, each negated when signed_div=1 and its sign bit is set; all arithmetic is mod 2^32.
REQ-008 DONE SHALL assert ready for exactly one cycle, then return to IDLE unconditionally; start is ignored in DONE.
REQ-009 ready SHALL rise in the 33rd cycle after the start cycle (start at cycle 0, ready at cycle 33).
REQ-010 stall_o SHALL be combinational: 1 when (IDLE and start and not annul) or BUSY; 0 in DONE and otherwise.
REQ-011 annul=1 in IDLE or BUSY SHALL force IDLE next cycle, with no ready pulse and result unchanged.
REQ-012 annul=1 in DONE SHALL NOT suppress that cycle's ready; the exception logic masks the HI/LO write.
REQ-013 result SHALL hold its value until the next BUSY->DONE transition.
REQ-014 Divisor zero SHALL complete with hi = opa and lo = 0xFFFFFFFF; lo = 0x00000001 instead when signed_div=1 and opa[31]=1.
REQ-015 The quotient 0x80000000 / 0xFFFFFFFF (signed) SHALL give lo = 0x80000000, hi = 0, with no trap.
REQ-016 start SHALL be accepted in the IDLE cycle immediately after DONE (back-to-back divides).

Reset
REQ-017 rst=1 SHALL force IDLE, counter 0, result 0, ready 0, and stall_o 0 in the following cycle, whatever the state (including mid-BUSY).
REQ-018 rst SHALL take priority over start and annul.

Configuration
REQ-019 With macro DIV_ZERO_FAST_EN defined, IDLE with start=1, annul=0 and opb=0 SHALL go directly to DONE, loading the REQ-014 result; ready is then at cycle 1 and stall_o is 1 only in the start cycle.
REQ-020 Without DIV_ZERO_FAST_EN, a zero divisor SHALL take the full 33-cycle path and produce the identical REQ-014 result.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- DIVU 100/7 -> ready at cycle 33, result = {0x00000002, 0x0000000E}; stall_o high cycles 0-32, low at 33.
- DIV -7/2 (0xFFFFFFF9/0x00000002) -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo = 0x80000000, hi = 0x00000000.
- DIVU 20/3 with annul at BUSY cycle 10 -> no ready, IDLE next cycle, result unchanged; then restart 20/3 -> lo = 6, hi = 2 at cycle 33 of the new start.
- DIVU 5/0 -> hi = 5, lo = 0xFFFFFFFF; ready at cycle 33 without DIV_ZERO_FAST_EN, cycle 1 with it. DIV 0xFFFFFFFB/0 -> lo = 0x00000001.
- rst at BUSY cycle 15 -> next cycle IDLE, result 0, ready 0, stall_o 0; back-to-back DIVU 9/3 then 10/4 -> results {0,3} and {2,2}, second start accepted the cycle after the first ready.
